sample_framer: RTL and testbench
================================

# sample_framer

Receiving end of the 12-bit sample stream produced by the DDS / ADC path. Collects offset-binary samples into fixed-length frames in a two-bank ping-pong buffer, converts them to two's complement, and streams complete frames to the FFT core over a valid/ready interface. One bank fills while the other drains, so the FFT sees gap-free, index-tagged frames.

## Interface
- FRAME_LEN, 1024, samples per frame; power of two, 4..4096
- ADDR_W, 10, log2(FRAME_LEN)
- clk  in  1  rising-edge clock for all logic
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  in_data valid this cycle
- in_data  in  12  offset-binary sample, 0..4095, midscale 2048
- out_valid  out  1  out_data/out_index/out_last valid
- out_ready  in  1  FFT accepts the current word
- out_data  out  12  two's-complement sample, in_data with MSB inverted
- out_index  out  ADDR_W  position of the word within its frame, 0..FRAME_LEN-1
- out_last  out  1  high with out_index == FRAME_LEN-1
- frame_count  out  16  frames fully delivered; wraps 65535->0
- overflow  out  1  sticky; a sample was dropped
- ovf_clr  in  1  clears overflow

## Operation
- Storage: 2 x FRAME_LEN x 12 bits. Each bank is FREE, FILLING, FULL or DRAINING.
- Writer FSM, W_IDLE / W_FILL:
  - W_IDLE: on in_valid with a FREE bank (bank 0 preferred on a tie), the sample goes to address 0 of that bank, the bank becomes FILLING, and the FSM moves to W_FILL with wr_addr=1.
  - W_FILL: each in_valid writes at wr_addr and increments it. Gaps in in_valid are allowed. The write at FRAME_LEN-1 makes the bank FULL and returns the FSM to W_IDLE.
  - in_valid in W_IDLE with no FREE bank: the sample is dropped and overflow is set. A frame in progress is never aborted.
- Reader FSM, R_IDLE / R_FETCH / R_STREAM:
  - R_IDLE: when a bank is FULL, it becomes DRAINING and the FSM moves to R_FETCH. Frames are drained in fill order.
  - R_FETCH: one-cycle synchronous memory read of address 0, then R_STREAM.
  - R_STREAM: the output register holds the word. On out_valid && out_ready, the next word is presented the following cycle with no bubble (read-ahead of next address, with a holding register while stalled).
  - The handshake on out_last sets the bank FREE, increments frame_count and returns to R_IDLE. If the other bank is already FULL, it goes R_IDLE -> R_FETCH the next cycle.
- Conversion: out_data = {~in_data[11], in_data[10:0]}. 0 -> -2048, 2048 -> 0, 4095 -> +2047.
- overflow: set has priority over ovf_clr in the same cycle.
- Bank-state hazard: a bank freed by the reader is usable by the writer on the cycle after the out_last handshake, not the same cycle.

## Timing
- Reset values: out_valid=0, out_data=0, out_index=0, out_last=0, frame_count=0, overflow=0, both banks FREE, FSMs in W_IDLE/R_IDLE.
- Reset mid-frame discards all buffered data. Stored memory contents are don't-care after reset.
- Latency: the final sample write at edge N gives out_valid=1 at edge N+2 (FULL seen N+1, fetch, data registered N+2).
- out_data, out_index and out_last stay stable while out_valid && !out_ready.
- out_valid never drops within a frame once asserted.
- Sustained throughput: 1 sample/clk in and out. No overflow while out_ready is held high.

## Configuration
- SAMPLE_FRAMER_TRIG_EN defined: in W_IDLE, a frame starts only on a rising zero crossing. This is the first in_valid sample with in_data >= 2048 whose previous valid sample was < 2048; that sample is index 0. Non-trigger samples in W_IDLE are discarded without setting overflow. If the trigger sample arrives with no FREE bank, overflow is set. The previous-sample register resets to 2048.
- Not defined: free-running capture as described above; no trigger logic.

## Test plan
- FRAME_LEN=8, rst pulse mid-stream -> all outputs at reset values asynchronously, frame_count=0; next capture starts at index 0.
- FRAME_LEN=8, in_data 0..7 with in_valid=1 and out_ready=1 -> out_valid at edge 10, out_data -2048..-2041, out_index 0..7, out_last on 7, frame_count=1.
- Inputs 0, 2048, 4095 -> out_data -2048, 0, +2047.
- out_ready toggling 1/0 every cycle over two back-to-back frames -> no lost or duplicated words, indices contiguous, data stable during stalls, frame_count=2.
- out_ready=0 and 20 valid samples with FRAME_LEN=8 -> 16 stored, 4 dropped, overflow=1; ovf_clr pulse -> 0. ovf_clr coinciding with a drop -> stays 1.
- SAMPLE_FRAMER_TRIG_EN, input sequence 3000, 1000, 1500, 2048, 2500... -> frame starts at sample 2048 (index 0), overflow stays 0.

Source files
------------

// File: rtl/sample_framer.sv
// sample_framer: two-bank ping-pong frame buffer turning an offset-binary sample stream into
// index-tagged two's-complement frames on a valid/ready port. Optional macro: SAMPLE_FRAMER_TRIG_EN.
module sample_framer #(
  parameter int FRAME_LEN = 1024,
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0]        out_index,
  output logic                     out_last,
  output logic [15:0]              frame_count,
  output logic                     overflow,
  input  logic                     ovf_clr
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);
  localparam logic [DATA_W-1:0] MIDSCALE = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {B_FREE, B_FILLING, B_FULL, B_DRAINING} bank_st_e;
  typedef enum logic {W_IDLE, W_FILL} wr_st_e;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_STREAM} rd_st_e;

  function automatic logic signed [DATA_W-1:0] to_twos(input logic [DATA_W-1:0] x);
    return $signed({~x[DATA_W-1], x[DATA_W-2:0]});
  endfunction

  logic signed [DATA_W-1:0] mem [0:2*FRAME_LEN-1];

  bank_st_e bank_q [2];
  bank_st_e bank_d [2];

  wr_st_e                   wr_st_q, wr_st_d;
  logic                     wr_bank_q, wr_bank_d;
  logic [ADDR_W-1:0]        wr_addr_q, wr_addr_d;
  logic                     last_full_q, last_full_d;

  rd_st_e                   rd_st_q, rd_st_d;
  logic                     rd_bank_q, rd_bank_d;
  logic                     out_valid_q, out_valid_d;
  logic [ADDR_W-1:0]        out_index_q, out_index_d;
  logic                     out_last_q, out_last_d;
  logic signed [DATA_W-1:0] out_data_q;
  logic [15:0]              frame_cnt_q, frame_cnt_d;
  logic                     ovf_q, ovf_d;

  logic                     free0, free1, full0, full1;
  logic                     start_cond, start_bank;
  logic                     wr_start, wr_done, ovf_set;
  logic                     mem_we;
  logic [ADDR_W:0]          mem_waddr;
  logic                     rd_en, rd_claim, rd_release, rd_pick;
  logic [ADDR_W-1:0]        rd_addr, nxt_idx;

  assign free0 = (bank_q[0] == B_FREE);
  assign free1 = (bank_q[1] == B_FREE);
  assign full0 = (bank_q[0] == B_FULL);
  assign full1 = (bank_q[1] == B_FULL);

`ifdef SAMPLE_FRAMER_TRIG_EN
  // Previous valid sample, tracked on every valid input so a crossing can be seen at any time.
  logic [DATA_W-1:0] prev_q, prev_d;

  assign start_cond = (in_data >= MIDSCALE) && (prev_q < MIDSCALE);
  assign prev_d     = in_valid ? in_data : prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= MIDSCALE;
    else     prev_q <= prev_d;
  end
`else
  assign start_cond = 1'b1;
`endif

  // Writer: claims a free bank on frame start, fills it, marks it full on the last word.
  always_comb begin
    wr_st_d     = wr_st_q;
    wr_bank_d   = wr_bank_q;
    wr_addr_d   = wr_addr_q;
    last_full_d = last_full_q;
    start_bank  = ~free0;
    mem_we      = 1'b0;
    mem_waddr   = {wr_bank_q, wr_addr_q};
    wr_start    = 1'b0;
    wr_done     = 1'b0;
    ovf_set     = 1'b0;
    case (wr_st_q)
      W_IDLE: begin
        if (in_valid && start_cond) begin
          if (free0 || free1) begin
            wr_start  = 1'b1;
            wr_bank_d = start_bank;
            mem_we    = 1'b1;
            mem_waddr = {start_bank, {ADDR_W{1'b0}}};
            wr_addr_d = ADDR_W'(1);
            wr_st_d   = W_FILL;
          end else begin
            ovf_set = 1'b1;
          end
        end
      end
      W_FILL: begin
        if (in_valid) begin
          mem_we    = 1'b1;
          wr_addr_d = wr_addr_q + ADDR_W'(1);
          if (wr_addr_q == LAST_IDX) begin
            wr_done     = 1'b1;
            last_full_d = wr_bank_q;
            wr_st_d     = W_IDLE;
          end
        end
      end
      default: wr_st_d = W_IDLE;
    endcase
  end

  // Reader: the output register doubles as the memory read register, so a stall simply
  // withholds the read enable and the presented word stays put.
  always_comb begin
    rd_st_d     = rd_st_q;
    rd_bank_d   = rd_bank_q;
    out_valid_d = out_valid_q;
    out_index_d = out_index_q;
    out_last_d  = out_last_q;
    frame_cnt_d = frame_cnt_q;
    nxt_idx     = out_index_q + ADDR_W'(1);
    rd_addr     = nxt_idx;
    rd_en       = 1'b0;
    rd_claim    = 1'b0;
    rd_release  = 1'b0;
    rd_pick     = (full0 && full1) ? ~last_full_q : full1;
    case (rd_st_q)
      R_IDLE: begin
        if (full0 || full1) begin
          rd_claim  = 1'b1;
          rd_bank_d = rd_pick;
          rd_st_d   = R_FETCH;
        end
      end
      R_FETCH: begin
        rd_en       = 1'b1;
        rd_addr     = '0;
        out_valid_d = 1'b1;
        out_index_d = '0;
        out_last_d  = (LAST_IDX == '0);
        rd_st_d     = R_STREAM;
      end
      R_STREAM: begin
        if (out_valid_q && out_ready) begin
          if (out_last_q) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            rd_release  = 1'b1;
            frame_cnt_d = frame_cnt_q + 16'd1;
            rd_st_d     = R_IDLE;
          end else begin
            rd_en       = 1'b1;
            out_index_d = nxt_idx;
            out_last_d  = (nxt_idx == LAST_IDX);
          end
        end
      end
      default: rd_st_d = R_IDLE;
    endcase
  end

  // Writer and reader only ever touch a bank in disjoint states, so the updates never collide.
  always_comb begin
    bank_d = bank_q;
    if (wr_start)   bank_d[start_bank] = B_FILLING;
    if (wr_done)    bank_d[wr_bank_q]  = B_FULL;
    if (rd_claim)   bank_d[rd_pick]    = B_DRAINING;
    if (rd_release) bank_d[rd_bank_q]  = B_FREE;
  end

  assign ovf_d = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_q[0]   <= B_FREE;
      bank_q[1]   <= B_FREE;
      wr_st_q     <= W_IDLE;
      wr_bank_q   <= 1'b0;
      wr_addr_q   <= '0;
      last_full_q <= 1'b0;
      rd_st_q     <= R_IDLE;
      rd_bank_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
      frame_cnt_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      bank_q      <= bank_d;
      wr_st_q     <= wr_st_d;
      wr_bank_q   <= wr_bank_d;
      wr_addr_q   <= wr_addr_d;
      last_full_q <= last_full_d;
      rd_st_q     <= rd_st_d;
      rd_bank_q   <= rd_bank_d;
      out_valid_q <= out_valid_d;
      out_index_q <= out_index_d;
      out_last_q  <= out_last_d;
      frame_cnt_q <= frame_cnt_d;
      ovf_q       <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= to_twos(in_data);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        out_data_q <= '0;
    else if (rd_en) out_data_q <= mem[{rd_bank_q, rd_addr}];
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_index   = out_index_q;
  assign out_last    = out_last_q;
  assign frame_count = frame_cnt_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_sample_framer.sv
// Scoreboard bench for sample_framer with FRAME_LEN=8; the reference tracks occupied buffers
// and queued words rather than bank states.
module tb_sample_framer;
  localparam int L  = 8;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic [11:0] in_data = '0;
  logic out_ready = 1'b0;
  logic ovf_clr = 1'b0;
  logic out_valid, out_last, overflow;
  logic signed [11:0] out_data;
  logic [AW-1:0] out_index;
  logic [15:0] frame_count;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  sample_framer #(.FRAME_LEN(L), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .frame_count(frame_count),
    .overflow(overflow), .ovf_clr(ovf_clr)
  );

  typedef struct packed {
    logic signed [31:0] data;
    logic [31:0]        idx;
  } exp_t;

  exp_t exp_q[$];
  int   m_pos = 0;
  int   m_used = 0;
  int   m_frames = 0;
  int   m_prev = 2048;
  bit   m_ovf = 1'b0;
  bit   stall_prev = 1'b0;
  bit   accept, drop, hs_last, start_ok;

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model and monitor; runs on the falling edge, looking at what the next rising edge will see.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_pos = 0; m_used = 0; m_frames = 0; m_prev = 2048;
      m_ovf = 1'b0; stall_prev = 1'b0;
    end else begin
      check("overflow", overflow, m_ovf);
      check("frame_count", frame_count, m_frames % 65536);
      if (stall_prev) check("valid_hold", out_valid, 1);
      hs_last = 1'b0;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_word", out_valid, 0);
        end else begin
          check("data", out_data, exp_q[0].data);
          check("index", out_index, exp_q[0].idx);
          check("last", out_last, exp_q[0].idx == L-1);
          if (out_ready) begin
            hs_last = (exp_q[0].idx == L-1);
            void'(exp_q.pop_front());
          end
        end
      end
      stall_prev = out_valid && !out_ready;

      accept = 1'b0;
      drop   = 1'b0;
      if (in_valid) begin
`ifdef SAMPLE_FRAMER_TRIG_EN
        start_ok = (int'(in_data) >= 2048) && (m_prev < 2048);
`else
        start_ok = 1'b1;
`endif
        if (m_pos != 0) accept = 1'b1;
        else if (start_ok) begin
          if (m_used < 2) begin accept = 1'b1; m_used++; end
          else drop = 1'b1;
        end
        if (accept) begin
          exp_q.push_back('{data: int'(in_data) - 2048, idx: m_pos});
          m_pos = (m_pos + 1) % L;
        end
        m_prev = int'(in_data);
      end
      if (drop) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
      if (hs_last) begin m_used--; m_frames++; end
    end
  end

  task automatic drive(input bit v, input int d, input bit r, input bit c = 1'b0);
    in_valid = v; in_data = d[11:0]; out_ready = r; ovf_clr = c;
    @(posedge clk); #1;
  endtask

  task automatic finish_frame();
    while (m_pos != 0) drive(1'b1, 3000, 1'b1);
  endtask

  task automatic drain();
    int n = 0;
    finish_frame();
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      drive(1'b0, 0, 1'b1);
      n++;
    end
    total++;
    if (exp_q.size() != 0 || out_valid) begin
      bad++;
      $display("FAIL drain: %0d words still pending, required 0", exp_q.size());
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_index"}, out_index, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_frame_count"}, frame_count, 0);
    check({tag, "_overflow"}, overflow, 0);
  endtask

  int base;
  int conv_seq[9] = '{1000, 2048, 0, 4095, 2048, 4095, 0, 2048, 100};
  int trig_seq[5] = '{3000, 1000, 1500, 2048, 2500};

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;

    // Single frame from idle: first-word latency and first frame count.
`ifdef SAMPLE_FRAMER_TRIG_EN
    drive(1'b1, 1000, 1'b1);
    base = 2048;
`else
    base = 0;
`endif
    for (int i = 0; i < L; i++) drive(1'b1, base + i, 1'b1);
    drive(1'b0, 0, 1'b1);
    check("latency_edge_n1", out_valid, 0);
    drive(1'b0, 0, 1'b1);
    check("latency_edge_n2", out_valid, 1);
    drain();
    check("frames_after_first", frame_count, 1);

    // Conversion endpoints.
    foreach (conv_seq[i]) drive(1'b1, conv_seq[i], 1'b1);
    drain();

    // Two back-to-back frames with out_ready toggling every cycle.
    drive(1'b1, 500, 1'b1);
    for (int i = 0; i < 2*L; i++)
      drive(1'b1, (i % L == 0) ? 3000 : ((i % L == L-1) ? 500 : int'($urandom_range(0, 4095))), i[0]);
    for (int i = 0; i < 40; i++) drive(1'b0, 0, i[0]);
    drain();

    // Overflow with the sink stalled, then clear and set/clear priority.
    for (int i = 0; i < 20; i++) drive(1'b1, (i % 2) ? 3000 : 1000, 1'b0);
    check("overflow_after_20", overflow, 1);
    drive(1'b0, 0, 1'b0, 1'b1);
    check("overflow_cleared", overflow, 0);
    drive(1'b1, 1000, 1'b0, 1'b1);
    drive(1'b1, 3000, 1'b0, 1'b1);
    check("overflow_set_beats_clr", overflow, 1);
    drive(1'b0, 0, 1'b0, 1'b1);
    check("overflow_cleared_again", overflow, 0);
    drain();

    // Zero-crossing trigger sequence.
    foreach (trig_seq[i]) drive(1'b1, trig_seq[i], 1'b1);
    for (int i = 0; i < L; i++) drive(1'b1, int'($urandom_range(0, 4095)), 1'b1);
    check("trig_no_overflow", overflow, 0);
    drain();

    // Random traffic.
    for (int i = 0; i < 400; i++)
      drive(($urandom % 4) != 0, int'($urandom_range(0, 4095)), ($urandom % 3) != 0, ($urandom % 16) == 0);
    drain();

    // Asynchronous reset in the middle of a stream, then a fresh capture.
    for (int i = 0; i < 13; i++)
      drive(1'b1, int'($urandom_range(0, 4095)), ($urandom % 2) != 0);
    #2 rst = 1'b1;
    #1;
    check_reset_values("midreset");
    in_valid = 1'b0; ovf_clr = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 12; i++) drive(1'b1, int'($urandom_range(0, 4095)), 1'b1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
